load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side load/store controller that sits between the single-cycle core's memory stage and a byte-wide, big-endian data memory port. It accepts one word, halfword or byte request from the core. It then sequences one memory byte per clock, driving address, read/write strobes and write byte. Load results are sign- or zero-extended and returned with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 6: byte-address width; the memory holds 2**ADDR_W bytes.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 1: core request; sampled only while `ready`=1.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `sign_ext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` in ADDR_W: start byte address.
- `wdata` in 32: store data, right-justified for byte/half.
- `ready` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: one-cycle pulse on rejected request (macro only).
- `rdata` out 32: load result; held until the next load completes.
- `mem_addr` out ADDR_W: byte address to memory.
- `mem_wdata` out 8: byte to write.
- `mem_rdata` in 8: byte from memory, combinational on `mem_addr`.
- `mem_read`, `mem_write` out 1: strobes; never both high.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE → XFER on `req`. Latch `we`, `size`, `sign_ext`, `addr`, `wdata`. Set byte count n = 1/2/4 and index k = 0.
- XFER:
  - `mem_addr` = latched addr + k, modulo 2**ADDR_W; wraps 63 → 0.
  - Store: `mem_write`=1 and `mem_wdata` = byte k of the operand, big-endian. Byte 0 is the most significant byte of the n-byte operand (word: wdata[31:24] first; half: wdata[15:8] first).
  - Load: `mem_read`=1. On the rising edge, `mem_rdata` is captured into the assembly register at the same big-endian position.
  - k increments each cycle. After byte n-1, go to DONE.
- DONE:
  - `done`=1 for one cycle.
  - For loads, `rdata` updates this cycle with the extended result. Byte: bit 7 extended; half: bit 15 extended; word: unchanged.
  - Stores leave `rdata` unchanged.
  - Next state is IDLE.
- `req` outside IDLE is ignored, not queued.
- Reset values:
  - state IDLE; `ready`=1.
  - `done`, `err`, `mem_read`, `mem_write` = 0.
  - `rdata`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-operation clears all outputs immediately because reset is asynchronous. Remaining bytes are abandoned; bytes already written stay in memory.

## Timing
- Request accepted at edge E0. Byte k is driven in cycle E0+1+k. `done` is high in cycle E0+1+n. `ready` returns at E0+2+n.
- Latency including the DONE cycle: byte 3, half 4, word 6 cycles from acceptance to `ready`.
- Memory strobes, address and write byte are registered and stable for the whole cycle. They suit a memory that writes on the falling edge and reads combinationally.
- `rdata` is valid from the DONE cycle onward.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - A half request with addr[0]=1, or a word request with addr[1:0]≠0, is rejected in IDLE.
  - On rejection, `err` pulses for one cycle (the cycle after acceptance), no memory strobe is issued, and the FSM stays in IDLE.
- Undefined:
  - `err` is tied to 0.
  - Any alignment is accepted, with address wrap-around.

## Structure
- Package `lsu_pkg` holds:
  - the `lsu_size_t` enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the `lsu_state_t` enum (IDLE, XFER, DONE);
  - a function mapping size to byte count.
- Optional sub-module `lsu_extend`: combinational sign/zero extension of the assembled value by size. Everything else lives in the top level.

## Test plan
- Memory bytes 0x10..0x13 = 12 34 56 78; word load from 0x10 → reads at 0x10..0x13 on consecutive cycles, `done` at E0+5, `rdata`=0x12345678.
- Byte 0x80 at 0x14: signed byte load → 0xFFFFFF80; unsigned → 0x00000080; `done` at E0+2.
- Half store of wdata 0x0000ABCD at 0x20 → two write cycles, mem[0x20]=AB, mem[0x21]=CD; `rdata` unchanged.
- Word load at 0x3E, bytes 0x3E..0x01 = 11 22 33 44:
  - macro undefined → addresses 3E, 3F, 00, 01 and `rdata`=0x11223344;
  - macro defined → `err` pulse, no `mem_read`, `ready` stays 1.
- Word store of 0xDEADBEEF at 0x08 with `rst_n` low after the second byte → strobes drop immediately; mem[0x08..0x09]=DE AD, mem[0x0A..0x0B] unchanged; `ready`=1 after release.
- `req` pulsed during XFER → ignored; exactly one `done` per accepted request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial big-endian load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } lsu_state_t;

    // Encoding 11 folds onto word.
    function automatic lsu_size_t decode_size(input logic [1:0] s);
        lsu_size_t r;
        if (s == 2'b00) r = SZ_BYTE;
        else if (s == 2'b01) r = SZ_HALF;
        else r = SZ_WORD;
        return r;
    endfunction

    function automatic logic [2:0] size_bytes(input lsu_size_t s);
        logic [2:0] r;
        unique case (s)
            SZ_BYTE: r = 3'd1;
            SZ_HALF: r = 3'd2;
            default: r = 3'd4;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the right-justified assembled load value.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] value,
    input  lsu_size_t   size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    always_comb begin
        result = value;
        unique case (size)
            SZ_BYTE: result = {{24{sign_ext & value[7]}}, value[7:0]};
            SZ_HALF: result = {{16{sign_ext & value[15]}}, value[15:0]};
            default: result = value;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial big-endian load/store controller between core and byte memory.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned half/word requests with err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_read,
    output logic              mem_write
);

    lsu_state_t  state;
    lsu_state_t  state_nxt;
    lsu_size_t   sz_in;
    lsu_size_t   size_q;
    logic        we_q;
    logic        sext_q;
    logic [1:0]  left;
    logic [23:0] sh;
    logic [23:0] asm_q;
    logic [31:0] asm_nxt;
    logic [31:0] wjust;
    logic [31:0] ext;
    logic [2:0]  n_req;
    logic        misaligned;
    logic        accept;
    logic        last;

    assign sz_in   = decode_size(size);
    assign n_req   = size_bytes(sz_in);
    assign ready   = (state == IDLE);
    assign accept  = ready & req & ~misaligned;
    assign last    = (state == XFER) && (left == 2'd0);
    assign asm_nxt = {asm_q, mem_rdata};

`ifdef LSU_ALIGN_CHECK_EN
    logic reject;
    assign misaligned = ((sz_in == SZ_HALF) && addr[0]) ||
                        ((sz_in == SZ_WORD) && (addr[1:0] != 2'b00));
    assign reject = ready & req & misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else err <= reject;
    end
`else
    assign misaligned = 1'b0;
    assign err = 1'b0;
`endif

    // Left-justify the operand so byte 0 is always the top byte.
    always_comb begin
        wjust = wdata;
        unique case (sz_in)
            SZ_BYTE: wjust = {wdata[7:0], 24'h0};
            SZ_HALF: wjust = {wdata[15:0], 16'h0};
            default: wjust = wdata;
        endcase
    end

    lsu_extend u_extend (
        .value    (asm_nxt),
        .size     (size_q),
        .sign_ext (sext_q),
        .result   (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = XFER;
            XFER:    if (left == 2'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            size_q    <= SZ_BYTE;
            left      <= 2'd0;
            sh        <= 24'h0;
            asm_q     <= 24'h0;
            rdata     <= 32'h0;
            mem_addr  <= '0;
            mem_wdata <= 8'h0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= last;
            if (accept) begin
                we_q      <= we;
                sext_q    <= sign_ext;
                size_q    <= sz_in;
                left      <= n_req[1:0] - 2'd1;
                mem_addr  <= addr;
                mem_wdata <= wjust[31:24];
                sh        <= wjust[23:0];
                asm_q     <= 24'h0;
                mem_read  <= ~we;
                mem_write <= we;
            end else if (state == XFER) begin
                left     <= left - 2'd1;
                mem_addr <= mem_addr + ADDR_W'(1);
                if (!we_q) asm_q <= asm_nxt[23:0];
                if (!last) begin
                    mem_wdata <= sh[23:16];
                    sh        <= {sh[15:0], 8'h0};
                    mem_read  <= ~we_q;
                    mem_write <= we_q;
                end else if (!we_q) begin
                    rdata <= ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [5:0]  addr = 6'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_read;
    logic        mem_write;

    logic [7:0]  mem [64];
    logic [7:0]  ref_mem [64];
    logic [31:0] exp_rdata;
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          accepted = 0;

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    load_store_unit #(.ADDR_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(negedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request from IDLE; model gives addresses, bytes and the result.
    task automatic do_op(input bit w, input logic [1:0] sz, input bit sx,
                         input logic [5:0] a, input logic [31:0] d, input bit hold);
        int n;
        bit bad;
        logic [31:0] v;
        logic [7:0] b;
        logic [5:0] ak;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad = ALIGN && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = hold;
        if (bad) begin
            req = 1'b0;
            check("err_pulse", err, 1);
            check("ready_rej", ready, 1);
            check("read_rej", mem_read, 0);
            check("write_rej", mem_write, 0);
            @(posedge clk); #1;
            check("err_clear", err, 0);
            return;
        end
        accepted++;
        v = 0;
        for (int k = 0; k < n; k++) begin
            ak = a + 6'(k);
            check("ready_busy", ready, 0);
            check("done_early", done, 0);
            check("err_quiet", err, 0);
            check("mem_addr", mem_addr, ak);
            check("mem_read", mem_read, !w);
            check("mem_write", mem_write, w);
            if (w) begin
                b = 8'(d >> (8 * (n - 1 - k)));
                check("mem_wdata", mem_wdata, b);
                ref_mem[ak] = b;
            end else begin
                v = (v << 8) | 32'(ref_mem[ak]);
            end
            @(posedge clk); #1;
        end
        if (!w) begin
            if (n < 4 && sx && v[8*n-1]) v = v - (32'd1 << (8 * n));
            exp_rdata = v;
        end
        req = 1'b0;
        check("done_pulse", done, 1);
        check("ready_done", ready, 0);
        check("read_done", mem_read, 0);
        check("write_done", mem_write, 0);
        check("rdata_done", rdata, exp_rdata);
        @(posedge clk); #1;
        check("done_clear", done, 0);
        check("ready_back", ready, 1);
        check("rdata_hold", rdata, exp_rdata);
        if (w) for (int k = 0; k < n; k++)
            check("mem_store", mem[a + 6'(k)], ref_mem[a + 6'(k)]);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
        mem[8'h14] = 8'h80;
        mem[8'h3E] = 8'h11; mem[8'h3F] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        exp_rdata = 32'h0;

        #2;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_read", mem_read, 0);
        check("rst_write", mem_write, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 1'b0);
        check("tp_word", rdata, 32'h12345678);
        do_op(1'b0, 2'd0, 1'b1, 6'h14, 32'h0, 1'b0);
        check("tp_sbyte", rdata, 32'hFFFFFF80);
        do_op(1'b0, 2'd0, 1'b0, 6'h14, 32'h0, 1'b0);
        check("tp_ubyte", rdata, 32'h00000080);
        do_op(1'b1, 2'd1, 1'b0, 6'h20, 32'h0000ABCD, 1'b0);
        check("tp_half_hi", mem[6'h20], 8'hAB);
        check("tp_half_lo", mem[6'h21], 8'hCD);
        check("tp_rdata_keep", rdata, 32'h00000080);
        do_op(1'b0, 2'd2, 1'b0, 6'h3E, 32'h0, 1'b0);
        if (!ALIGN) check("tp_wrap", rdata, 32'h11223344);
        do_op(1'b0, 2'd3, 1'b1, 6'h10, 32'h0, 1'b1);
        check("tp_hold_req", rdata, 32'h12345678);

        we = 1'b1; size = 2'd2; addr = 6'h08; wdata = 32'hDEADBEEF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_b0", mem_addr, 6'h08);
        @(posedge clk); #1;
        check("abort_b1", mem_addr, 6'h09);
        ref_mem[8'h08] = 8'hDE;
        ref_mem[8'h09] = 8'hAD;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_rdata = 32'h0;
        check("abort_write", mem_write, 0);
        check("abort_read", mem_read, 0);
        check("abort_ready", ready, 1);
        check("abort_addr", mem_addr, 0);
        check("abort_rdata", rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 8; i < 12; i++) check("abort_mem", mem[i], ref_mem[i]);
        @(posedge clk); #1;
        check("abort_idle", ready, 1);

        for (int t = 0; t < 60; t++)
            do_op(1'($urandom), 2'($urandom), 1'($urandom), 6'($urandom),
                  $urandom, 1'($urandom));

        repeat (2) @(posedge clk);
        #1;
        check("done_count", done_cnt, accepted);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
